sm2201_cycle_sequencer: RTL

SM2201_CYCLE_SEQUENCER -- requirements
Module: sm2201_cycle_sequencer

---
 rtl/sm2201_cycle_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sm2201_cycle_sequencer.sv
// sm2201_cycle_sequencer: bridges a 64-byte ISA I/O window onto CAMAC dataway
// cycles. Words 0..30 map to CAMAC subaddresses. Word 31 is a local status byte.
// An even-byte read or an odd-byte write launches a CAMAC cycle. isa_chrdy holds
// the ISA cycle in wait states until that CAMAC cycle completes.
// Optional feature macro: SM2201_SEQ_TIMEOUT_EN adds a response timeout in
// WAIT_RESP and a sticky seq_timeout flag.
module sm2201_cycle_sequencer #(
  parameter logic [9:0] BASE_ADDR      = 10'h100,
  parameter int         STROBE_CYCLES  = 2,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic        isa_clk,
  input  logic        isa_reset,
  input  logic [9:0]  isa_addr,
  input  logic        isa_ior,
  input  logic        isa_iow,
  input  logic        isa_aen,
  input  logic [7:0]  isa_data_in,
  output logic [7:0]  isa_data_out,
  output logic        isa_data_oe,
  output logic        isa_chrdy,
  input  logic [15:0] cb_data_in,
  output logic [15:0] cb_data_out,
  output logic        cb_data_oe,
  output logic [4:0]  cb_sub,
  output logic        cb_write,
  output logic        cb_strobe,
  input  logic        cb_zk4,
  input  logic        cb_prr,
  output logic        seq_busy,
  output logic        seq_timeout
);

  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
    $error("STROBE_CYCLES must be in 1..15");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [2:0] {IDLE, WAIT_BUS, STROBE, WAIT_RESP, DONE} state_t;
  state_t state, next_state;

  logic [10:0] addr_ext, base_ext;
  logic        in_window, rd_req, wr_req, hit, hit_prev, start;
  logic        odd_byte, is_status, trig_hit, launch;
  logic [4:0]  word;
  logic [7:0]  low_byte;
  logic [15:0] rd_latch;
  logic [3:0]  strobe_cnt;
  logic        strobe_last, timed_out;

  assign addr_ext    = {1'b0, isa_addr};
  assign base_ext    = {1'b0, BASE_ADDR};
  assign in_window   = (addr_ext >= base_ext) && (addr_ext < base_ext + 11'd64);
  assign rd_req      = !isa_ior && isa_iow;
  assign wr_req      = !isa_iow && isa_ior;
  assign hit         = !isa_aen && in_window && (rd_req || wr_req);
  assign start       = hit && !hit_prev;
  assign word        = isa_addr[5:1];
  assign odd_byte    = isa_addr[0];
  assign is_status   = (word == 5'd31);
  // Only even-byte reads and odd-byte writes of data words need the dataway.
  assign trig_hit    = hit && !is_status && ((rd_req && !odd_byte) || (wr_req && odd_byte));
  assign launch      = start && trig_hit && (state == IDLE);
  assign strobe_last = (strobe_cnt == 4'(STROBE_CYCLES - 1));

  // State register; reset aborts any CAMAC cycle in flight.
  always_ff @(posedge isa_clk or posedge isa_reset) begin
    if (isa_reset) state <= IDLE;
    else           state <= next_state;
  end

  // Next-state decode plus dataway and ISA handshake outputs.
  always_comb begin
    next_state   = state;
    cb_strobe    = 1'b0;
    seq_busy     = (state != IDLE);
    cb_data_oe   = 1'b0;
    isa_chrdy    = 1'b1;
    isa_data_oe  = 1'b0;
    isa_data_out = 8'h00;
    case (state)
      IDLE:      if (launch) next_state = WAIT_BUS;
      WAIT_BUS:  if (cb_zk4) next_state = STROBE;
      STROBE: begin
        cb_strobe = 1'b1;
        if (strobe_last) next_state = WAIT_RESP;
      end
      WAIT_RESP: if (!cb_prr || timed_out) next_state = DONE;
      // An aborted ISA command simply finds hit already low here.
      DONE:      if (!hit) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
    if (state != IDLE) cb_data_oe = cb_write;
    if (!isa_reset) begin
      if (trig_hit && state != DONE) isa_chrdy = 1'b0;
      isa_data_oe = hit && rd_req;
    end
    if (is_status)     isa_data_out = {seq_timeout, seq_busy, 6'b0};
    else if (odd_byte) isa_data_out = rd_latch[15:8];
    else               isa_data_out = rd_latch[7:0];
  end

  // Command edge detect, low-byte staging, CAMAC cycle latches and strobe timing.
  // hit_prev resets high so a command already asserted at reset release is ignored.
  always_ff @(posedge isa_clk or posedge isa_reset) begin
    if (isa_reset) begin
      hit_prev    <= 1'b1;
      low_byte    <= 8'h00;
      rd_latch    <= 16'h0000;
      cb_sub      <= 5'd0;
      cb_write    <= 1'b0;
      cb_data_out <= 16'h0000;
      strobe_cnt  <= 4'd0;
    end else begin
      hit_prev <= hit;
      if (start && wr_req && !odd_byte && !is_status) low_byte <= isa_data_in;
      if (launch) begin
        cb_sub   <= word;
        cb_write <= wr_req;
        if (wr_req) cb_data_out <= {isa_data_in, low_byte};
      end
      if (state == STROBE) strobe_cnt <= strobe_cnt + 4'd1;
      else                 strobe_cnt <= 4'd0;
      if (state == WAIT_RESP) begin
        if (!cb_prr) begin
          if (!cb_write) rd_latch <= cb_data_in;
        end else if (timed_out) begin
          rd_latch <= 16'hFFFF;
        end
      end
    end
  end

`ifdef SM2201_SEQ_TIMEOUT_EN
  logic [7:0] resp_cnt;
  logic       timeout_flag, status_rd, status_rd_prev;

  assign status_rd   = hit && rd_req && is_status;
  assign timed_out   = (state == WAIT_RESP) && (resp_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign seq_timeout = timeout_flag;

  // Response watchdog and sticky flag; a new timeout wins over a status-read clear.
  always_ff @(posedge isa_clk or posedge isa_reset) begin
    if (isa_reset) begin
      resp_cnt       <= 8'd0;
      timeout_flag   <= 1'b0;
      status_rd_prev <= 1'b0;
    end else begin
      if (state == WAIT_RESP) resp_cnt <= resp_cnt + 8'd1;
      else                    resp_cnt <= 8'd0;
      status_rd_prev <= status_rd;
      if (timed_out && cb_prr)               timeout_flag <= 1'b1;
      else if (status_rd_prev && !status_rd) timeout_flag <= 1'b0;
    end
  end
`else
  assign timed_out   = 1'b0;
  assign seq_timeout = 1'b0;
`endif

endmodule
